// File: rtl/ccd_capture_if.sv
// Pixel-stream bundle between the sensor pin registers and the capture stage.
// The master side drives the sensor strobes and controls; the slave side drives the qualified stream.
interface ccd_capture_if;
  logic [11:0] iDATA;
  logic        iFVAL;
  logic        iLVAL;
  logic        iSTART;
  logic        iEND;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic [31:0] oFrame_Cont;

  modport master (
    output iDATA, iFVAL, iLVAL, iSTART, iEND,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL, iSTART, iEND,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont
  );
endinterface

// File: rtl/ccd_capture.sv
// Sensor front-end capture: gates whole frames on start/stop, qualifies pixels with FVAL/LVAL
// and tracks column, row and frame counters for the downstream pixel pipeline.
module ccd_capture #(
  parameter int unsigned COLUMN_WIDTH = 1280
) (
  input logic          iCLK,
  input logic          iRST,
  ccd_capture_if.slave bus
);

  localparam logic [15:0] XLast = 16'(COLUMN_WIDTH - 1);

  logic        start_q, start_d;
  logic        pre_fval_q;
  logic        fval_q, fval_d;
  logic        lval_q;
  logic [11:0] data_q, data_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [31:0] frame_q, frame_d;

  // iEND has priority so a simultaneous start/stop leaves capture disabled.
  always_comb begin
    start_d = start_q;
    if (bus.iEND) begin
      start_d = 1'b0;
    end else if (bus.iSTART) begin
      start_d = 1'b1;
    end
  end

  // Only a rising FVAL opens a frame, so a frame already running always completes.
  always_comb begin
    fval_d  = fval_q;
    frame_d = frame_q;
    if (!pre_fval_q && bus.iFVAL && start_q) begin
      fval_d  = 1'b1;
      frame_d = frame_q + 32'd1;
    end else if (pre_fval_q && !bus.iFVAL) begin
      fval_d = 1'b0;
    end
  end

  assign data_d = bus.iLVAL ? bus.iDATA : 12'd0;

  // Rows are delimited only by the column wrap; X holds across line blanking.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!fval_q) begin
      x_d = 16'd0;
      y_d = 16'd0;
    end else if (lval_q) begin
      if (x_q < XLast) begin
        x_d = x_q + 16'd1;
      end else begin
        x_d = 16'd0;
        y_d = y_q + 16'd1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      start_q    <= 1'b0;
      pre_fval_q <= 1'b0;
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      data_q     <= 12'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      frame_q    <= 32'd0;
    end else begin
      start_q    <= start_d;
      pre_fval_q <= bus.iFVAL;
      fval_q     <= fval_d;
      lval_q     <= bus.iLVAL;
      data_q     <= data_d;
      x_q        <= x_d;
      y_q        <= y_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.oDATA       = data_q;
  assign bus.oDVAL       = fval_q & lval_q;
  assign bus.oX_Cont     = x_q;
  assign bus.oY_Cont     = y_q;
  assign bus.oFrame_Cont = frame_q;

endmodule

// File: tb/tb_ccd_capture.sv
// Self-checking bench for ccd_capture: table of frame scenarios plus hand sequences for reset,
// frame end and frame-counter wrap; pixels are checked through an expected-pixel queue.
module tb_ccd_capture;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccd_capture_if bus();

  ccd_capture #(.COLUMN_WIDTH(W)) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [11:0] data;
    logic [15:0] x;
    logic [15:0] y;
  } pix_t;

  typedef struct {
    logic        s;
    logic        e;
    int          lines;
    int          gap;
    logic        end_mid;
    logic [11:0] base;
    logic        exp_cap;
    logic [31:0] exp_frames;
  } vec_t;

  pix_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic lval_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) lval_s <= bus.iLVAL;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.oDVAL === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_dval: got oDVAL=1 data=0x%0h, expected no pixel (t=%0t)",
                   bus.oDATA, $time);
        end else begin
          pix_t p;
          p = exp_q.pop_front();
          check("pix_data", 32'(bus.oDATA), 32'(p.data));
          check("pix_x", 32'(bus.oX_Cont), 32'(p.x));
          check("pix_y", 32'(bus.oY_Cont), 32'(p.y));
        end
      end else if (!lval_s) begin
        check("blank_data", 32'(bus.oDATA), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic lv, input logic [11:0] d, input logic cap,
                       inout int n);
    bus.iFVAL = fv;
    bus.iLVAL = lv;
    bus.iDATA = d;
    if (cap && fv && lv) begin
      pix_t p;
      p.data = d;
      p.x    = 16'(n % W);
      p.y    = 16'(n / W);
      exp_q.push_back(p);
      n++;
    end
    cyc();
  endtask

  task automatic ctl(input logic s, input logic e);
    bus.iSTART = s;
    bus.iEND   = e;
    cyc();
    bus.iSTART = 1'b0;
    bus.iEND   = 1'b0;
    cyc();
  endtask

  task automatic frame(input int lines, input int gap, input logic cap, input logic end_mid,
                       input logic [11:0] base);
    int n = 0;
    int k = 0;
    drive(1'b1, 1'b0, 12'h000, cap, n);
    drive(1'b1, 1'b0, 12'h000, cap, n);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < W; p++) begin
        if (end_mid && l == 0 && p == 1) bus.iEND = 1'b1;
        drive(1'b1, 1'b1, base + 12'(k), cap, n);
        bus.iEND = 1'b0;
        k++;
      end
      for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, 12'hABC, cap, n);
    end
    for (int t = 0; t < 3; t++) drive(1'b0, 1'b0, 12'h000, cap, n);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{1'b1, 1'b0, 2, 1, 1'b0, 12'h100, 1'b1, 32'd1};
    tbl[1] = '{1'b0, 1'b0, 3, 3, 1'b0, 12'h200, 1'b1, 32'd2};
    tbl[2] = '{1'b0, 1'b0, 2, 2, 1'b1, 12'h300, 1'b1, 32'd3};
    tbl[3] = '{1'b0, 1'b0, 2, 1, 1'b0, 12'h400, 1'b0, 32'd3};
    tbl[4] = '{1'b0, 1'b0, 1, 1, 1'b0, 12'h500, 1'b0, 32'd3};
    tbl[5] = '{1'b1, 1'b0, 1, 2, 1'b0, 12'h600, 1'b1, 32'd4};
    tbl[6] = '{1'b1, 1'b1, 2, 1, 1'b0, 12'h700, 1'b0, 32'd4};

    bus.iDATA = 12'h000; bus.iFVAL = 1'b0; bus.iLVAL = 1'b0;
    bus.iSTART = 1'b0; bus.iEND = 1'b0;

    // Reset with random inputs, then a frame with capture disabled.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.iDATA  = 12'($urandom);
      bus.iFVAL  = 1'($urandom);
      bus.iLVAL  = 1'($urandom);
      bus.iSTART = 1'($urandom);
      bus.iEND   = 1'b0;
      cyc();
      check("rst_odata", 32'(bus.oDATA), 32'd0);
      check("rst_odval", 32'(bus.oDVAL), 32'd0);
      check("rst_ox", 32'(bus.oX_Cont), 32'd0);
      check("rst_oy", 32'(bus.oY_Cont), 32'd0);
      check("rst_oframe", bus.oFrame_Cont, 32'd0);
    end
    bus.iDATA = 12'h000; bus.iFVAL = 1'b0; bus.iLVAL = 1'b0; bus.iSTART = 1'b0;
    rst_n = 1'b1;
    cyc();
    mon_en = 1'b1;
    frame(2, 1, 1'b0, 1'b0, 12'h050);
    check("no_start_frames", bus.oFrame_Cont, 32'd0);

    // Reset mid-frame: FVAL held high across release must not open a frame.
    ctl(1'b1, 1'b0);
    n = 0;
    drive(1'b1, 1'b0, 12'h000, 1'b1, n);
    drive(1'b1, 1'b1, 12'h0A0, 1'b1, n);
    drive(1'b1, 1'b1, 12'h0A1, 1'b1, n);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 12'h000, 1'b0, n);
    drive(1'b1, 1'b0, 12'h000, 1'b0, n);
    rst_n = 1'b1;
    bus.iSTART = 1'b1;
    drive(1'b1, 1'b0, 12'h000, 1'b0, n);
    bus.iSTART = 1'b0;
    for (int p = 0; p < W; p++) drive(1'b1, 1'b1, 12'h0B0 + 12'(p), 1'b0, n);
    for (int t = 0; t < 3; t++) drive(1'b0, 1'b0, 12'h000, 1'b0, n);
    check("rst_mid_queue", 32'(exp_q.size()), 32'd0);
    check("rst_mid_frames", bus.oFrame_Cont, 32'd0);
    ctl(1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].s || tbl[i].e) ctl(tbl[i].s, tbl[i].e);
      frame(tbl[i].lines, tbl[i].gap, tbl[i].exp_cap, tbl[i].end_mid, tbl[i].base);
      check($sformatf("row%0d_frames", i), bus.oFrame_Cont, tbl[i].exp_frames);
    end

    // FVAL falls while LVAL is still high.
    ctl(1'b1, 1'b0);
    n = 0;
    drive(1'b1, 1'b0, 12'h000, 1'b1, n);
    for (int p = 0; p < W + 2; p++) drive(1'b1, 1'b1, 12'hC00 + 12'(p), 1'b1, n);
    drive(1'b0, 1'b1, 12'hCFF, 1'b1, n);
    check("fend_dval", 32'(bus.oDVAL), 32'd0);
    check("fend_x_hold", 32'(bus.oX_Cont), 32'd2);
    check("fend_y_hold", 32'(bus.oY_Cont), 32'd1);
    drive(1'b0, 1'b0, 12'h000, 1'b1, n);
    check("fend_x_clr", 32'(bus.oX_Cont), 32'd0);
    check("fend_y_clr", 32'(bus.oY_Cont), 32'd0);
    check("fend_frames", bus.oFrame_Cont, 32'd5);
    frame(2, 1, 1'b1, 1'b0, 12'h800);
    check("after_fend_frames", bus.oFrame_Cont, 32'd6);

    // Frame counter wrap from all-ones.
    force dut.frame_q = 32'hFFFF_FFFF;
    #1;
    release dut.frame_q;
    check("wrap_preload", bus.oFrame_Cont, 32'hFFFF_FFFF);
    frame(1, 1, 1'b1, 1'b0, 12'h900);
    check("wrap_frames", bus.oFrame_Cont, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
